// File: rtl/pe_array_seq.sv
// pe_array_seq: job sequencer for an NxN PE array (clear, weight load, run, drain).
// Optional RUN stall counter enabled by defining SEQ_STALL_CNT_EN.
module pe_array_seq #(
  parameter int N             = 3,
  parameter int NUM_COL_WIDTH = $clog2(N+1),
  parameter int SEL_WIDTH     = $clog2(N),
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [NUM_COL_WIDTH-1:0] filter_size_i,
  input  logic [CNT_WIDTH-1:0]     num_windows_i,
  input  logic                     feat_vld_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     pe_rst_o,
  output logic                     pe_load_o,
  output logic                     pe_ready_o,
  output logic                     pe_start_op_o,
  output logic [SEL_WIDTH-1:0]     f_sel_o,
  output logic [NUM_COL_WIDTH-1:0] row_num_o,
  output logic [NUM_COL_WIDTH-1:0] column_num_o,
  output logic [NUM_COL_WIDTH-1:0] filter_size_o,
  output logic [CNT_WIDTH-1:0]     stall_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_READY,
    S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [NUM_COL_WIDTH-1:0] fs;
  logic [CNT_WIDTH-1:0]     nw;
  logic [CNT_WIDTH-1:0]     win;
  logic [CNT_WIDTH-1:0]     cnt;
  logic [SEL_WIDTH-1:0]     fsel;

  logic legal, accept, wrap;
  logic last_row, last_drain, last_win;

  assign legal  = (filter_size_i != '0)
               && (32'(filter_size_i) <= N);
  assign accept = (state == S_IDLE) && start_i && legal;
  assign wrap   = 32'(fsel) == 32'(fs) - 32'd1;

  assign last_row   = cnt == CNT_WIDTH'(fs) - CNT_WIDTH'(1);
  assign last_drain = cnt == CNT_WIDTH'(fs) + CNT_WIDTH'(1);
  assign last_win   = (win + CNT_WIDTH'(1)) == nw;

  // Job fields and counters only move on the state they belong to.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      fs    <= '0;
      nw    <= '0;
      win   <= '0;
      cnt   <= '0;
      fsel  <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        S_IDLE: if (accept) begin
          fs   <= filter_size_i;
          nw   <= num_windows_i;
          win  <= '0;
          cnt  <= '0;
          fsel <= '0;
        end
        S_CLEAR: cnt <= '0;
        S_LOAD:  cnt <= cnt + CNT_WIDTH'(1);
        S_READY: cnt <= '0;
        S_RUN: if (feat_vld_i) begin
          if (wrap) begin
            fsel <= '0;
            win  <= win + CNT_WIDTH'(1);
          end else begin
            fsel <= fsel + SEL_WIDTH'(1);
          end
        end
        S_DRAIN: cnt <= cnt + CNT_WIDTH'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_LOAD;
      S_LOAD:  if (last_row) state_nxt = S_READY;
      S_READY: state_nxt = (nw == '0) ? S_DRAIN : S_RUN;
      S_RUN:
        if (feat_vld_i && wrap && last_win)
          state_nxt = S_DRAIN;
      S_DRAIN: if (last_drain) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  logic                     busy_d, done_d, err_d;
  logic                     rst_d, load_d, ready_d, op_d;
  logic [SEL_WIDTH-1:0]     fsel_d;
  logic [NUM_COL_WIDTH-1:0] row_d, fs_d;

  always_comb begin
    busy_d = state != S_IDLE;
    done_d = state == S_DONE;
    err_d  = (state == S_IDLE) && start_i && !legal;
    rst_d  = state == S_CLEAR;
    load_d = state == S_LOAD;
    ready_d = state == S_READY;
    op_d   = (state == S_RUN) && feat_vld_i;
    fsel_d = (state == S_RUN) ? fsel : '0;
    row_d  = (state == S_LOAD) ? cnt[NUM_COL_WIDTH-1:0] : '0;
    fs_d   = busy_d ? fs : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      pe_rst_o      <= 1'b0;
      pe_load_o     <= 1'b0;
      pe_ready_o    <= 1'b0;
      pe_start_op_o <= 1'b0;
      f_sel_o       <= '0;
      row_num_o     <= '0;
      column_num_o  <= '0;
      filter_size_o <= '0;
    end else begin
      busy_o        <= busy_d;
      done_o        <= done_d;
      err_o         <= err_d;
      pe_rst_o      <= rst_d;
      pe_load_o     <= load_d;
      pe_ready_o    <= ready_d;
      pe_start_op_o <= op_d;
      f_sel_o       <= fsel_d;
      row_num_o     <= row_d;
      column_num_o  <= fs_d;
      filter_size_o <= fs_d;
    end
  end

`ifdef SEQ_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if ((state == S_RUN) && !feat_vld_i
                 && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_WIDTH'(1);
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pe_array_seq.sv
// Directed bench for pe_array_seq: table of jobs plus reset-mid-run sequence.
// Expected stall counts depend on SEQ_STALL_CNT_EN.
module tb_pe_array_seq;

  localparam int N   = 3;
  localparam int NCW = 2;
  localparam int SW  = 2;
  localparam int CW  = 16;

`ifdef SEQ_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           start_i;
  logic [NCW-1:0] filter_size_i;
  logic [CW-1:0]  num_windows_i;
  logic           feat_vld_i;
  logic           busy_o, done_o, err_o;
  logic           pe_rst_o, pe_load_o;
  logic           pe_ready_o, pe_start_op_o;
  logic [SW-1:0]  f_sel_o;
  logic [NCW-1:0] row_num_o, column_num_o;
  logic [NCW-1:0] filter_size_o;
  logic [CW-1:0]  stall_cnt_o;

  pe_array_seq #(.N(N)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .start_i(start_i),
    .filter_size_i(filter_size_i),
    .num_windows_i(num_windows_i),
    .feat_vld_i(feat_vld_i),
    .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .pe_rst_o(pe_rst_o),
    .pe_load_o(pe_load_o),
    .pe_ready_o(pe_ready_o),
    .pe_start_op_o(pe_start_op_o),
    .f_sel_o(f_sel_o),
    .row_num_o(row_num_o),
    .column_num_o(column_num_o),
    .filter_size_o(filter_size_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  logic [30:0] outs;
  assign outs = {busy_o, done_o, err_o, pe_rst_o,
                 pe_load_o, pe_ready_o, pe_start_op_o,
                 f_sel_o, row_num_o, column_num_o,
                 filter_size_o, stall_cnt_o};

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input string nm,
                     input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s.%s got %0d want %0d",
               tag, nm, act, exp);
    end
  endtask

  // stall/xstart: bit c applies to the clock edge c cycles after start.
  typedef struct {
    int          fs;
    int          nw;
    logic [63:0] stall;
    logic [63:0] xstart;
    int          busy;
    int          n_load;
    int          n_start;
    int          quiet;
    int          done;
    int          err;
    int          stall_exp;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input string tag);
    int busy = 0, nrst = 0, nload = 0, nready = 0;
    int nstart = 0, ndone = 0, nerr = 0;
    int quiet = 0, qcap = -1;
    int seqerr = 0, cfgerr = 0, excl = 0;
    int ns, ecfg;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (c > 0) begin
        ns = int'(pe_rst_o) + int'(pe_load_o)
           + int'(pe_ready_o) + int'(pe_start_op_o);
        if (ns > 1) excl++;
        if (busy_o) busy++;
        if (pe_rst_o) nrst++;
        if (pe_ready_o) nready++;
        if (err_o) nerr++;
        if (pe_load_o) begin
          if (int'(row_num_o) != nload) seqerr++;
          nload++;
        end
        if (pe_start_op_o) begin
          if (v.fs <= 0 || int'(f_sel_o) != nstart % v.fs)
            seqerr++;
          nstart++;
        end
        if (done_o) begin
          ndone++;
          qcap = quiet;
        end
        if (ns != 0) quiet = 0;
        else if (busy_o && !done_o) quiet++;
        ecfg = busy_o ? v.fs : 0;
        if (int'(column_num_o) != ecfg
            || int'(filter_size_o) != ecfg)
          cfgerr++;
      end
      start_i       = (c == 0) || v.xstart[c];
      filter_size_i = (c == 0) ? NCW'(v.fs) : NCW'(1);
      num_windows_i = (c == 0) ? CW'(v.nw) : CW'(7);
      feat_vld_i    = !v.stall[c];
    end
    start_i = 1'b0;
    chk(tag, "busy_cycles", busy, v.busy);
    chk(tag, "pe_rst", nrst, v.done);
    chk(tag, "pe_load", nload, v.n_load);
    chk(tag, "pe_ready", nready, v.done);
    chk(tag, "pe_start_op", nstart, v.n_start);
    chk(tag, "drain_len", qcap, v.quiet);
    chk(tag, "done", ndone, v.done);
    chk(tag, "err", nerr, v.err);
    chk(tag, "row_fsel_seq", seqerr, 0);
    chk(tag, "cfg_fields", cfgerr, 0);
    chk(tag, "strobe_onehot", excl, 0);
    chk(tag, "stall_cnt", int'(stall_cnt_o),
        STALL_EN ? v.stall_exp : 0);
  endtask

  initial begin
    vecs[0] = '{0, 1, 64'd0, 64'd0, 0, 0, 0, -1, 0, 1, 0};
    // 4 does not fit the 2-bit field; it arrives as 0
    vecs[1] = '{4, 1, 64'd0, 64'd0, 0, 0, 0, -1, 0, 1, 0};
    vecs[2] = '{3, 2, 64'd0, 64'd0, 17, 3, 6, 5, 1, 0, 0};
    vecs[3] = '{3, 2, 64'h680, 64'd0, 20, 3, 6, 5, 1, 0, 3};
    vecs[4] = '{2, 0, 64'd0, 64'd0, 9, 2, 0, 4, 1, 0, 0};
    vecs[5] = '{1, 3, 64'd0, 64'd0, 10, 1, 3, 3, 1, 0, 0};
    vecs[6] = '{2, 1, 64'h20, 64'd0, 12, 2, 2, 4, 1, 0, 1};
    vecs[7] = '{3, 2, 64'd0, 64'h2008, 17, 3, 6, 5, 1, 0, 0};

    rst_i = 1'b1;
    start_i = 1'b0;
    filter_size_i = '0;
    num_windows_i = '0;
    feat_vld_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("reset", "outs", int'(outs), 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_reset", "outs", int'(outs), 0);

    for (int i = 0; i < 8; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // reset lands on the 4th RUN cycle (edge 9 after start)
    begin
      int seen_done = 0, seen_busy = 0, n_op = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk_i);
        if (pe_start_op_o) n_op++;
        start_i       = (c == 0);
        filter_size_i = NCW'(3);
        num_windows_i = CW'(2);
        feat_vld_i    = 1'b1;
        rst_i         = (c == 9);
      end
      @(negedge clk_i);
      chk("midrun", "ops_before_rst", n_op, 3);
      chk("midrun", "outs_after_rst", int'(outs), 0);
      rst_i = 1'b0;
      for (int c = 0; c < 15; c++) begin
        @(negedge clk_i);
        if (done_o) seen_done++;
        if (busy_o) seen_busy++;
      end
      chk("midrun", "no_done", seen_done, 0);
      chk("midrun", "stays_idle", seen_busy, 0);
    end
    run_vec(vecs[2], "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
